// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one full-subtractor cell per clock.
// Optional feature macro SERIAL_SUB_OVF_EN adds the two's-complement overflow flag output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_s;
    logic             br_next_s;
    logic             accept_s;
    logic             last_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current operand LSBs plus handshake decode
    always_comb begin
        bit_s     = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next_s = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        accept_s  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        last_s    = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and datapath update; outputs are derived from the next state so they are registered
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept_s) begin
            sa_d    = a;
            sb_d    = b;
            br_d    = borrow_in;
            cnt_d   = {CW{1'b0}};
            state_d = ST_SHIFT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    res_d = {bit_s, res_q[WIDTH-1:1]};
                    sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                    sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                    br_d  = br_next_s;
                    cnt_d = cnt_q + CW'(1);
                    if (last_s) begin
                        diff_d  = {bit_s, res_q[WIDTH-1:1]};
                        bout_d  = br_next_s;
`ifdef SERIAL_SUB_OVF_EN
                        // br_q is the borrow into the MSB on the last step
                        ovf_d   = br_q ^ br_next_s;
`endif
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= {WIDTH{1'b0}};
            sb_q    <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8), plus a model-checked operand sweep.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, scramble operands afterwards, then wait (bounded) for done.
    // busy_cycles counts busy samples; done_cycle is the sample index (1 = right after start edge).
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output int busy_cycles, output int done_cycle);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        tick();
        start = 1'b0; a = ~av; b = ~bv; borrow_in = ~bi;
        busy_cycles = 0;
        done_cycle  = 0;
        for (int k = 1; k <= W + 4; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_cycle = k;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int bc, dc;
        do_op(8'h5A, 8'h23, 1'b0, bc, dc);
        checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        checks++; if (dc !== 9) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=9", dc); end
        checks++; if (diff !== 8'h37) begin failures++; $display("FAIL basic_diff got=%h exp=37", diff); end
        checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL basic_bout got=%b exp=0", borrow_out); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_after_done got busy=%b done=%b exp 0 0", busy, done);
        end
        checks++; if (diff !== 8'h37) begin failures++; $display("FAIL basic_diff_held got=%h exp=37", diff); end
    endtask

    task automatic test_borrow();
        int bc, dc;
        do_op(8'h10, 8'h20, 1'b0, bc, dc);
        checks++; if (dc !== 9) begin failures++; $display("FAIL borrow1_done_cycle got=%0d exp=9", dc); end
        checks++; if (diff !== 8'hF0) begin failures++; $display("FAIL borrow1_diff got=%h exp=f0", diff); end
        checks++; if (borrow_out !== 1'b1) begin failures++; $display("FAIL borrow1_bout got=%b exp=1", borrow_out); end
        tick();
        do_op(8'h00, 8'h00, 1'b1, bc, dc);
        checks++; if (dc !== 9) begin failures++; $display("FAIL borrow2_done_cycle got=%0d exp=9", dc); end
        checks++; if (diff !== 8'hFF) begin failures++; $display("FAIL borrow2_diff got=%h exp=ff", diff); end
        checks++; if (borrow_out !== 1'b1) begin failures++; $display("FAIL borrow2_bout got=%b exp=1", borrow_out); end
        tick();
    endtask

    task automatic test_ignore_start();
        int n_done;
        logic [W-1:0] seen;
        n_done = 0; seen = 8'h00;
        a = 8'h5A; b = 8'h23; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hFF; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin
                n_done++;
                seen = diff;
            end
            tick();
        end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        checks++; if (seen !== 8'h37) begin failures++; $display("FAIL ignore_diff got=%h exp=37", seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{8'h5A, 8'hC8, 8'h01};
        logic [W-1:0] vb [3] = '{8'h23, 8'h64, 8'h02};
        logic         vi [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] ed [3] = '{8'h37, 8'h63, 8'hFE};
        logic         eb [3] = '{1'b0, 1'b0, 1'b1};
        int dc;
        a = va[0]; b = vb[0]; borrow_in = vi[0]; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            dc = 0;
            for (int k = 1; k <= W + 4; k++) begin
                if (done) begin
                    dc = k;
                    break;
                end
                tick();
            end
            checks++; if (dc !== 9) begin failures++; $display("FAIL b2b_period[%0d] got=%0d exp=9", i, dc); end
            checks++; if (diff !== ed[i] || borrow_out !== eb[i]) begin
                failures++;
                $display("FAIL b2b_result[%0d] got=%h/%b exp=%h/%b", i, diff, borrow_out, ed[i], eb[i]);
            end
            if (i < 2) begin
                a = va[i+1]; b = vb[i+1]; borrow_in = vi[i+1];
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int bc, dc, n_done;
        n_done = 0;
        a = 8'h5A; b = 8'h23; borrow_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL areset_ctl got busy=%b done=%b exp 0 0", busy, done);
        end
        checks++; if (diff !== 8'h00 || borrow_out !== 1'b0) begin
            failures++; $display("FAIL areset_result got=%h/%b exp=00/0", diff, borrow_out);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) n_done++;
            tick();
        end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL areset_no_done got=%0d exp=0", n_done); end
        do_op(8'h05, 8'h03, 1'b0, bc, dc);
        checks++; if (dc !== 9) begin failures++; $display("FAIL areset_after_cycle got=%0d exp=9", dc); end
        checks++; if (diff !== 8'h02 || borrow_out !== 1'b0) begin
            failures++; $display("FAIL areset_after_result got=%h/%b exp=02/0", diff, borrow_out);
        end
        tick();
    endtask

    task automatic test_ovf();
        int bc, dc;
        do_op(8'h80, 8'h01, 1'b0, bc, dc);
        checks++; if (diff !== 8'h7F || borrow_out !== 1'b0) begin
            failures++; $display("FAIL ovf1_result got=%h/%b exp=7f/0", diff, borrow_out);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf1_flag got=%b exp=1", ovf); end
`endif
        tick();
        do_op(8'h05, 8'h03, 1'b0, bc, dc);
        checks++; if (diff !== 8'h02 || borrow_out !== 1'b0) begin
            failures++; $display("FAIL ovf2_result got=%h/%b exp=02/0", diff, borrow_out);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf2_flag got=%b exp=0", ovf); end
`endif
        tick();
    endtask

    task automatic test_random();
        int bc, dc, sr;
        logic [W-1:0] ra, rb;
        logic         ri;
        logic [W:0]   full;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            ri = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, ri};
            sr = $signed(ra) - $signed(rb) - int'(ri);
            do_op(ra, rb, ri, bc, dc);
            checks++; if (dc !== 9 || diff !== full[W-1:0] || borrow_out !== full[W]) begin
                failures++;
                $display("FAIL rand[%0d] a=%h b=%h bi=%b got=%h/%b cyc=%0d exp=%h/%b cyc=9",
                         n, ra, rb, ri, diff, borrow_out, dc, full[W-1:0], full[W]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++; if (ovf !== ((sr < -128) || (sr > 127))) begin
                failures++; $display("FAIL rand_ovf[%0d] a=%h b=%h bi=%b got=%b", n, ra, rb, ri, ovf);
            end
`endif
            if (n[0]) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_ovf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
